// File: rtl/axi_fifo_pkt_arb.sv
// -----------------------------------------------------------------------------
// axi_fifo_pkt_arb
//
// Packet-granular round-robin arbiter that shares one block-RAM AXI FIFO
// between NUM_INPUTS AXI-stream requesters. A requester is granted only when
// the FIFO reports room for a worst-case packet (MAX_PKT_LINES beats). An
// admitted packet therefore never stalls mid-transfer on a full FIFO. A packet
// longer than MAX_PKT_LINES beats is cut off at the limit. The sticky overrun
// flag records that this happened.
//
// Ports
//   clk         clock
//   reset       synchronous active-high reset
//   clear       synchronous flush, same effect as reset
//   i_tdata     requester data, requester k at [k*WIDTH +: WIDTH]
//   i_tlast     end-of-packet per requester
//   i_tvalid    valid per requester
//   i_tready    ready per requester (only the granted one can be high)
//   fifo_space  free lines reported by the shared FIFO
//   o_tdata     data to the FIFO
//   o_tlast     end-of-packet to the FIFO (also forced at the length limit)
//   o_tvalid    valid to the FIFO
//   o_tready    FIFO ready
//   grant_valid high while a packet is being forwarded
//   grant_id    index of the granted requester (held while idle)
//   overrun     sticky: a packet was truncated at MAX_PKT_LINES beats
// -----------------------------------------------------------------------------
module axi_fifo_pkt_arb #(
    parameter int WIDTH         = 32,
    parameter int NUM_INPUTS    = 4,
    parameter int MAX_PKT_LINES = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [NUM_INPUTS*WIDTH-1:0]  i_tdata,
    input  logic [NUM_INPUTS-1:0]        i_tlast,
    input  logic [NUM_INPUTS-1:0]        i_tvalid,
    output logic [NUM_INPUTS-1:0]        i_tready,
    input  logic [15:0]                  fifo_space,
    output logic [WIDTH-1:0]             o_tdata,
    output logic                         o_tlast,
    output logic                         o_tvalid,
    input  logic                         o_tready,
    output logic                         grant_valid,
    output logic [2:0]                   grant_id,
    output logic                         overrun
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [15:0] MAX_LINES_C = 16'(MAX_PKT_LINES);
    localparam logic [15:0] LAST_IDX_C  = 16'(MAX_PKT_LINES - 1);

    state_t             state_q, state_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic [15:0]        beat_cnt_q, beat_cnt_d;
    logic               overrun_q, overrun_d;

    // Requester flags zero-extended to 8 bits so a 3-bit index always fits.
    logic [7:0]         valid_pad_s;
    logic [WIDTH-1:0]   sel_tdata_s;
    logic               sel_tvalid_s;
    logic               sel_tlast_s;
    logic [NUM_INPUTS-1:0] grant_oh_s;
    logic               win_found_s;
    logic [2:0]         win_idx_s;
    logic [2:0]         cand_s;
    logic               at_limit_s;
    logic               last_s;

    // (base + offs) mod NUM_INPUTS; base < NUM_INPUTS and offs <= NUM_INPUTS.
    function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_INPUTS) begin
            sum = sum - NUM_INPUTS;
        end else begin
            sum = sum;
        end
        return 3'(sum);
    endfunction

    assign valid_pad_s = 8'(i_tvalid);

    // Select the granted requester's stream and build its one-hot grant mask.
    always_comb begin
        sel_tdata_s  = '0;
        sel_tvalid_s = 1'b0;
        sel_tlast_s  = 1'b0;
        grant_oh_s   = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (grant_id_q == 3'(k)) begin
                sel_tdata_s   = i_tdata[k*WIDTH +: WIDTH];
                sel_tvalid_s  = i_tvalid[k];
                sel_tlast_s   = i_tlast[k];
                grant_oh_s[k] = 1'b1;
            end else begin
                grant_oh_s[k] = 1'b0;
            end
        end
    end

    // Round-robin search: first valid requester starting at rr_ptr.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 3'd0;
        cand_s      = 3'd0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cand_s = wrap_idx(rr_ptr_q, i);
            if (!win_found_s && valid_pad_s[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign at_limit_s = (beat_cnt_q == LAST_IDX_C);

    // Next-state and pass-through outputs of the IDLE/SEND controller.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        overrun_d  = overrun_q;
        i_tready   = '0;
        o_tdata    = '0;
        o_tvalid   = 1'b0;
        o_tlast    = 1'b0;
        last_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Admission needs room for a whole worst-case packet, so the
                // packet can never stall mid-transfer on FIFO capacity.
                if (win_found_s && (fifo_space >= MAX_LINES_C)) begin
                    state_d    = ST_SEND;
                    grant_id_d = win_idx_s;
                    beat_cnt_d = 16'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                last_s   = sel_tlast_s | at_limit_s;
                o_tdata  = sel_tdata_s;
                o_tvalid = sel_tvalid_s;
                o_tlast  = last_s;
                i_tready = o_tready ? grant_oh_s : '0;
                if (sel_tvalid_s && o_tready) begin
                    if (last_s) begin
                        state_d    = ST_IDLE;
                        rr_ptr_d   = wrap_idx(grant_id_q, 1);
                        beat_cnt_d = 16'd0;
                        // Ending on the length limit rather than the source's
                        // own tlast means the packet was cut short.
                        if (!sel_tlast_s) begin
                            overrun_d = 1'b1;
                        end else begin
                            overrun_d = overrun_q;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 16'd1;
                    end
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with reset and flush.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 3'd0;
            grant_id_q <= 3'd0;
            beat_cnt_q <= 16'd0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    assign grant_valid = (state_q == ST_SEND);
    assign grant_id    = grant_id_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_axi_fifo_pkt_arb.sv
// -----------------------------------------------------------------------------
// Testbench for axi_fifo_pkt_arb. Randomized sources and sink, checked every
// cycle against a packet-level reference model kept in the bench.
// -----------------------------------------------------------------------------
module tb_axi_fifo_pkt_arb;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int MAXL  = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clear;
    logic [N*WIDTH-1:0]   i_tdata;
    logic [N-1:0]         i_tlast;
    logic [N-1:0]         i_tvalid;
    logic [N-1:0]         i_tready;
    logic [15:0]          fifo_space;
    logic [WIDTH-1:0]     o_tdata;
    logic                 o_tlast;
    logic                 o_tvalid;
    logic                 o_tready;
    logic                 grant_valid;
    logic [2:0]           grant_id;
    logic                 overrun;

    always #5 clk = ~clk;

    axi_fifo_pkt_arb #(
        .WIDTH(WIDTH), .NUM_INPUTS(N), .MAX_PKT_LINES(MAXL)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .fifo_space(fifo_space),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .grant_valid(grant_valid), .grant_id(grant_id), .overrun(overrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sources: per requester a running sequence number and beats left in packet.
    int unsigned seq [N];
    int          rem [N];

    // Reference model: is a packet in flight, whose, where the search starts,
    // beats sent in the current grant, sticky truncation flag, grant history.
    bit m_busy;
    int m_gid;
    int m_rr;
    int m_cnt;
    bit m_ovr;
    int grants[$];

    // One clock: drive inputs, check outputs, advance model, step to next edge.
    task automatic cycle(input bit rst, input bit clr, input logic [N-1:0] vmask,
                         input int vpct, input int rpct, input int lmin, input int lmax,
                         input logic [15:0] space);
        logic [N-1:0] exp_rdy;
        bit src_last;
        bit exp_last;
        bit beat;
        int win;
        for (int k = 0; k < N; k++) begin
            if (rem[k] == 0) rem[k] = $urandom_range(lmax, lmin);
            i_tdata[k*WIDTH +: WIDTH] = {8'(k), 24'(seq[k])};
            i_tlast[k]  = (rem[k] == 1);
            i_tvalid[k] = vmask[k] && ($urandom_range(99, 0) < vpct);
        end
        o_tready   = ($urandom_range(99, 0) < rpct);
        fifo_space = space;
        reset      = rst;
        clear      = clr;
        #1;
        src_last = 1'b0;
        exp_last = 1'b0;
        beat     = 1'b0;
        check_eq("grant_valid", grant_valid, m_busy);
        check_eq("grant_id", grant_id, m_gid);
        check_eq("overrun", overrun, m_ovr);
        if (m_busy) begin
            exp_rdy = '0;
            if (o_tready) exp_rdy[m_gid] = 1'b1;
            check_eq("i_tready", i_tready, exp_rdy);
            check_eq("o_tvalid", o_tvalid, i_tvalid[m_gid]);
            if (i_tvalid[m_gid]) begin
                src_last = (rem[m_gid] == 1);
                exp_last = src_last || (m_cnt == MAXL - 1);
                check_eq("o_tdata", o_tdata, {8'(m_gid), 24'(seq[m_gid])});
                check_eq("o_tlast", o_tlast, exp_last);
                beat = o_tready;
            end
        end else begin
            check_eq("i_tready_idle", i_tready, '0);
            check_eq("o_tvalid_idle", o_tvalid, 1'b0);
        end
        // Model update at the coming edge.
        if (rst || clr) begin
            m_busy = 1'b0; m_rr = 0; m_gid = 0; m_cnt = 0; m_ovr = 1'b0;
        end else if (!m_busy) begin
            if (i_tvalid != '0 && int'(space) >= MAXL) begin
                win = -1;
                for (int i = 0; i < N; i++) begin
                    if (win < 0 && i_tvalid[(m_rr + i) % N]) win = (m_rr + i) % N;
                end
                m_busy = 1'b1; m_gid = win; m_cnt = 0;
                grants.push_back(win);
            end
        end else if (beat) begin
            if (exp_last) begin
                m_busy = 1'b0; m_rr = (m_gid + 1) % N; m_cnt = 0;
                if (!src_last) m_ovr = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        // A handshake consumes the source's current beat even under clear.
        if (m_busy || beat) begin
            if (beat) begin
                seq[m_gid == -1 ? 0 : m_gid] = seq[m_gid == -1 ? 0 : m_gid];
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Sources are advanced by the bench from its own expected handshake.
    int last_gid;

    task automatic run(input bit rst, input bit clr, input logic [N-1:0] vmask,
                       input int vpct, input int rpct, input int lmin, input int lmax,
                       input logic [15:0] space);
        bit was_busy;
        int g;
        logic tv;
        logic tr;
        was_busy = m_busy;
        g        = m_gid;
        cycle(rst, clr, vmask, vpct, rpct, lmin, lmax, space);
        tv = i_tvalid[g];
        tr = o_tready;
        if (was_busy && tv && tr) begin
            seq[g] = seq[g] + 1;
            rem[g] = rem[g] - 1;
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            seq[k] = 32'(k * 1000);
            rem[k] = 0;
        end
        m_busy = 1'b0; m_gid = 0; m_rr = 0; m_cnt = 0; m_ovr = 1'b0;
        reset = 1'b1; clear = 1'b0; i_tvalid = '1; i_tlast = '0; i_tdata = '0;
        o_tready = 1'b1; fifo_space = 16'd1024;
        @(posedge clk);
        #1;

        // Reset held with every requester valid, then the first free cycle.
        repeat (3) run(1'b1, 1'b0, 4'b1111, 100, 100, 3, 3, 16'd1024);
        grants.delete();
        run(1'b0, 1'b0, 4'b1111, 100, 100, 3, 3, 16'd1024);

        // Round-robin with continuous 3-beat packets.
        repeat (40) run(1'b0, 1'b0, 4'b1111, 100, 100, 3, 3, 16'd1024);
        check_eq("rr_order0", 64'(grants[0]), 64'd0);
        check_eq("rr_order1", 64'(grants[1]), 64'd1);
        check_eq("rr_order2", 64'(grants[2]), 64'd2);
        check_eq("rr_order3", 64'(grants[3]), 64'd3);
        check_eq("rr_order4", 64'(grants[4]), 64'd0);

        // Admission boundary: one line short of a worst-case packet, then enough.
        run(1'b0, 1'b1, 4'b0100, 100, 100, 3, 3, 16'(MAXL - 1));
        repeat (20) run(1'b0, 1'b0, 4'b0100, 100, 100, 3, 3, 16'(MAXL - 1));
        run(1'b0, 1'b0, 4'b0100, 100, 100, 3, 3, 16'(MAXL));
        check_eq("adm_grant_valid", grant_valid, 1'b1);
        check_eq("adm_grant_id", grant_id, 3'd2);
        check_eq("adm_ready", i_tready, 4'b0100);

        // Directed overrun: 10-beat packets against an 8-beat limit.
        run(1'b0, 1'b1, 4'b0001, 100, 100, 10, 10, 16'd1024);
        repeat (30) run(1'b0, 1'b0, 4'b0001, 100, 100, 10, 10, 16'd1024);
        check_eq("ovr_set", overrun, 1'b1);
        repeat (10) run(1'b0, 1'b0, 4'b1111, 100, 100, 2, 4, 16'd1024);
        check_eq("ovr_sticky", overrun, 1'b1);
        run(1'b0, 1'b1, 4'b0000, 100, 100, 3, 3, 16'd1024);
        check_eq("ovr_cleared", overrun, 1'b0);

        // Clear on beat 2 of a 5-beat packet from requester 2.
        for (int k = 0; k < N; k++) rem[k] = 0;
        run(1'b0, 1'b0, 4'b0100, 100, 100, 5, 5, 16'd1024);
        run(1'b0, 1'b0, 4'b0100, 100, 100, 5, 5, 16'd1024);
        run(1'b0, 1'b1, 4'b0100, 100, 100, 5, 5, 16'd1024);
        check_eq("clr_idle", grant_valid, 1'b0);
        check_eq("clr_ready", i_tready, 4'b0000);
        run(1'b0, 1'b0, 4'b1111, 100, 100, 5, 5, 16'd1024);
        check_eq("clr_restart", 64'(grants[$]), 64'd0);

        // Backpressure and gaps with a space level around the threshold.
        repeat (300) run(1'b0, 1'b0, 4'b1111, 70, 50, 1, 6,
                         16'($urandom_range(MAXL + 2, MAXL - 2)));

        // Everything random: long packets, occasional clear, wide space range.
        repeat (500) run(1'b0, ($urandom_range(99, 0) < 2), 4'($urandom),
                         80, 60, 1, 14,
                         ($urandom_range(1, 0) == 1) ? 16'($urandom) :
                                                       16'($urandom_range(MAXL + 1, 0)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_fifo_pkt_arb.md
Name: axi_fifo_pkt_arb

Overview:
- Packet-granular round-robin arbiter that shares one block-RAM AXI FIFO between NUM_INPUTS upstream AXI-stream requesters.
- Grants a requester only when the FIFO reports room for a worst-case packet, so an admitted packet never stalls mid-transfer on a full FIFO.
- Sits directly in front of the shared FIFO's input port and consumes that FIFO's space output.

Parameters:
- WIDTH, 32, data width of every stream.
- NUM_INPUTS, 4, number of requesters; legal range 2..8.
- MAX_PKT_LINES, 256, worst-case packet length in beats; admission threshold and overrun limit; legal range 1..65535.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- clear  input  1  synchronous flush; same effect as reset
- i_tdata  input  NUM_INPUTS*WIDTH  requester data; requester k occupies bits [k*WIDTH +: WIDTH]
- i_tlast  input  NUM_INPUTS  end-of-packet per requester
- i_tvalid  input  NUM_INPUTS  valid per requester
- i_tready  output  NUM_INPUTS  ready per requester
- fifo_space  input  16  free lines reported by the shared FIFO
- o_tdata  output  WIDTH  data to the FIFO
- o_tlast  output  1  end-of-packet to the FIFO
- o_tvalid  output  1  valid to the FIFO
- o_tready  input  1  FIFO ready
- grant_valid  output  1  high while a packet is being forwarded
- grant_id  output  3  index of the granted requester
- overrun  output  1  sticky flag: a packet was truncated

Behaviour:
- Reset and clear set state to IDLE, rr_ptr=0, grant_id=0, beat_cnt=0 and overrun=0.
  - grant_valid, o_tvalid and every i_tready bit drop low in the cycle after reset or clear is sampled.
  - A clear asserted mid-packet abandons that packet. The FIFO sees a packet without tlast; the FIFO owner flushes it with its own clear.
- IDLE state:
  - All i_tready bits are 0 and o_tvalid is 0.
  - A requester is eligible when its i_tvalid is 1.
  - A grant requires any(i_tvalid)=1 and fifo_space >= MAX_PKT_LINES, with the comparison done unsigned in 16 bits.
  - Winner: the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_INPUTS.
  - On the next edge: state goes to SEND, grant_id takes the winner index, and beat_cnt=0.
- SEND state, combinational pass-through of the granted requester g=grant_id:
  - o_tdata=i_tdata[g], o_tvalid=i_tvalid[g], and i_tready[g]=o_tready.
  - All other i_tready bits are 0.
  - o_tlast = i_tlast[g] | (beat_cnt == MAX_PKT_LINES-1).
  - A beat is o_tvalid & o_tready. Each beat increments beat_cnt.
  - A beat with o_tlast=1 ends the packet. On the next edge: state goes to IDLE, rr_ptr=(g+1) mod NUM_INPUTS, beat_cnt=0.
  - If o_tlast was forced while i_tlast[g]=0, overrun is set. overrun is cleared only by reset or clear.
  - After a forced end, the remainder of the requester's packet is arbitrated later as a new packet.
- Latency and throughput:
  - First beat of a grant can transfer one cycle after the IDLE decision.
  - There is exactly one idle cycle between consecutive packets.
  - A one-beat packet takes 2 cycles per grant.
- fifo_space is sampled only in IDLE. A space drop during SEND has no effect, because the threshold reserved room for the whole packet.
- A requester deasserting i_tvalid mid-packet keeps the grant; no other requester is serviced until that packet's tlast beat.
- grant_valid = (state==SEND). grant_id holds its value in IDLE.

Test Plan:
- Reset: hold reset 3 cycles while all i_tvalid=1 -> i_tready=0, o_tvalid=0, grant_valid=0, overrun=0 during reset and on the first cycle after release.
- Round-robin: NUM_INPUTS=4, all inputs continuously offer 3-beat packets, fifo_space=1024, o_tready=1 -> grant order 0,1,2,3,0; each packet is 3 beats followed by 1 idle cycle; no beat is interleaved between requesters.
- Admission: MAX_PKT_LINES=256 with fifo_space=255 and input 2 valid -> no grant for 20 cycles. Raise fifo_space to 256 -> grant_id=2 on the next cycle and the first beat transfers that cycle.
- Backpressure and gaps: toggle o_tready every cycle and drop i_tvalid[1] for 2 cycles mid-packet -> data arrives in order and unduplicated, the grant stays on 1, and only i_tready[1] ever goes high.
- Overrun: MAX_PKT_LINES=4 and input 0 sends 6 beats with tlast on beat 6 -> beat 4 carries o_tlast=1 and overrun becomes 1. Beats 5-6 go out as a new 2-beat packet after the other requesters' turns. overrun stays 1 until clear.
- Clear mid-packet: assert clear on beat 2 of a 5-beat packet -> the next cycle shows IDLE, rr_ptr=0 and i_tready=0. Arbitration restarts from input 0.
